serial_out_cmd_ctrl: RTL and testbench

Command controller between the UART receiver/transmitter and a bank of diff_freq_serial_out channels. It assembles PACK_NUM-byte packets from UART rx bytes: pattern bytes first, then one control byte. It validates each packet, dispatches load/start/stop strobes to the addressed channel, and returns a one-byte acknowledge or error code over UART tx. It also reports channel completion events back to the host as notification bytes, arbitrated by fixed priority.

---
 rtl/serial_out_cmd_pkg.sv | 32 +++
 rtl/done_notify_arb.sv | 39 +++
 rtl/serial_out_cmd_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_serial_out_cmd_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_out_cmd_pkg.sv
// Shared definitions for the serial-out command controller: FSM states,
// control-byte field positions and the host-visible response codes.
package serial_out_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DECODE,
    ST_LOAD,
    ST_START,
    ST_ACK,
    ST_ACK_WAIT
  } state_t;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_MODE  = 2;
  localparam int CTRL_CH_LO = 3;
  localparam int CTRL_CH_HI = 6;

  localparam logic [7:0] ACK_BASE     = 8'hA0;
  localparam logic [7:0] NOTIFY_BASE  = 8'hD0;
  localparam logic [7:0] ERR_TIMEOUT  = 8'hE1;
  localparam logic [7:0] ERR_CH       = 8'hE2;
  localparam logic [7:0] ERR_CONFLICT = 8'hE3;
  localparam logic [7:0] ERR_BUSY     = 8'hE4;

  function automatic logic [7:0] idx_code(input logic [7:0] base, input logic [3:0] idx);
    return base | {4'b0000, idx};
  endfunction

endpackage

// File: rtl/done_notify_arb.sv
// Sticky per-channel done flags with a lowest-index-first grant; the granted
// flag clears on the grant cycle unless a new done for it arrives then.
module done_notify_arb #(
  parameter int CH_NUM = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] done_tick,
  input  logic              grant,
  output logic              pend_any,
  output logic [3:0]        pend_idx
);

  logic [CH_NUM-1:0] pend_q;
  logic [CH_NUM-1:0] clr_mask;

  always_comb begin
    pend_idx = 4'd0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (pend_q[k]) pend_idx = 4'(k);
    end
  end

  always_comb begin
    clr_mask = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      clr_mask[k] = grant && (pend_idx == 4'(k));
    end
  end

  assign pend_any = |pend_q;

  // A done arriving on the grant cycle must survive, so OR it in after the clear.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) pend_q <= '0;
    else       pend_q <= (pend_q & ~clr_mask) | done_tick;
  end

endmodule

// File: rtl/serial_out_cmd_ctrl.sv
// Packet assembler / dispatcher between the UART and the serial-out channels;
// acknowledges each packet and forwards channel completion notifications.
module serial_out_cmd_ctrl #(
  parameter int DATA_BIT    = 8,
  parameter int PACK_NUM    = 3,
  parameter int CH_NUM      = 2,
  parameter int TIMEOUT_CLK = 10420,
  parameter int TO_BIT      = 14
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_BIT-1:0]            i_rx_data,
  input  logic                           i_rx_done_tick,
  input  logic [CH_NUM-1:0]              i_ch_busy,
  input  logic [CH_NUM-1:0]              i_ch_done_tick,
  output logic [DATA_BIT*(PACK_NUM-1)-1:0] o_pattern,
  output logic [CH_NUM-1:0]              o_ch_mode,
  output logic [CH_NUM-1:0]              o_ch_load,
  output logic [CH_NUM-1:0]              o_ch_start,
  output logic [CH_NUM-1:0]              o_ch_stop,
  output logic                           o_tx_start,
  output logic [7:0]                     o_tx_data,
  input  logic                           i_tx_done_tick,
  output logic                           o_overrun_tick
);
  import serial_out_cmd_pkg::*;

  localparam int PW = DATA_BIT * (PACK_NUM - 1);
  localparam int CW = (PACK_NUM > 2) ? $clog2(PACK_NUM) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(PACK_NUM - 1);
  localparam logic [TO_BIT-1:0] TO_LAST  = TO_BIT'(TIMEOUT_CLK - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [TO_BIT-1:0]   to_q;
  logic [PW-1:0]       pat_sh, pat_next, pattern_q;
  logic [6:0]          ctrl_q;
  logic [CH_NUM-1:0]   mode_q;
  logic [7:0]          code_q;

  logic [3:0]          ch;
  logic                start_bit, stop_bit, mode_bit, busy_sel;
  logic [CH_NUM-1:0]   ch_oh;
  logic                dec_err;
  logic [7:0]          dec_code;

  logic                pend_any, grant;
  logic [3:0]          pend_idx;

  logic [CH_NUM-1:0]   load_v, start_v, stop_v;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic                overrun;

  done_notify_arb #(.CH_NUM(CH_NUM)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .done_tick (i_ch_done_tick),
    .grant     (grant),
    .pend_any  (pend_any),
    .pend_idx  (pend_idx)
  );

  // First received byte ends up in the MSB byte after PACK_NUM-1 shifts.
  if (PACK_NUM > 2) begin : g_shift
    assign pat_next = {pat_sh[PW-DATA_BIT-1:0], i_rx_data};
  end else begin : g_single
    assign pat_next = i_rx_data;
  end

  assign ch        = ctrl_q[CTRL_CH_HI:CTRL_CH_LO];
  assign start_bit = ctrl_q[CTRL_START];
  assign stop_bit  = ctrl_q[CTRL_STOP];
  assign mode_bit  = ctrl_q[CTRL_MODE];

  always_comb begin
    ch_oh    = '0;
    busy_sel = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      ch_oh[k] = (ch == 4'(k));
      if (ch == 4'(k)) busy_sel = i_ch_busy[k];
    end
  end

  always_comb begin
    dec_err  = 1'b1;
    dec_code = ERR_CH;
    if ({1'b0, ch} >= 5'(CH_NUM)) begin
      dec_code = ERR_CH;
    end else if (start_bit && stop_bit) begin
      dec_code = ERR_CONFLICT;
    end else if (start_bit && busy_sel) begin
      dec_code = ERR_BUSY;
    end else begin
      dec_err  = 1'b0;
      dec_code = ACK_BASE;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_v   = '0;
    start_v  = '0;
    stop_v   = '0;
    tx_start = 1'b0;
    tx_data  = code_q;
    grant    = 1'b0;
    overrun  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_done_tick) begin
          state_d = ST_COLLECT;
        end else if (pend_any) begin
          grant    = 1'b1;
          tx_start = 1'b1;
          tx_data  = idx_code(NOTIFY_BASE, pend_idx);
          state_d  = ST_ACK_WAIT;
        end
      end
      ST_COLLECT: begin
        if (i_rx_done_tick) begin
          if (cnt_q == CNT_LAST) state_d = ST_DECODE;
        end else if (to_q == TO_LAST) begin
          state_d = ST_ACK;
        end
      end
      ST_DECODE: begin
        overrun = i_rx_done_tick;
        state_d = dec_err ? ST_ACK : ST_LOAD;
      end
      ST_LOAD: begin
        overrun = i_rx_done_tick;
        if (stop_bit) stop_v = ch_oh;
        else          load_v = ch_oh;
        state_d = ST_START;
      end
      ST_START: begin
        overrun = i_rx_done_tick;
        if (start_bit) start_v = ch_oh;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        overrun  = i_rx_done_tick;
        tx_start = 1'b1;
        state_d  = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        overrun = i_rx_done_tick;
        if (i_tx_done_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q     <= '0;
      to_q      <= '0;
      pat_sh    <= '0;
      ctrl_q    <= '0;
      pattern_q <= '0;
      mode_q    <= '0;
      code_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_rx_done_tick) begin
            pat_sh <= pat_next;
            cnt_q  <= CW'(1);
            to_q   <= '0;
          end else if (pend_any) begin
            code_q <= idx_code(NOTIFY_BASE, pend_idx);
          end
        end
        ST_COLLECT: begin
          if (i_rx_done_tick) begin
            to_q <= '0;
            if (cnt_q == CNT_LAST) begin
              ctrl_q <= i_rx_data[6:0];
            end else begin
              pat_sh <= pat_next;
              cnt_q  <= cnt_q + CW'(1);
            end
          end else if (to_q == TO_LAST) begin
            code_q <= ERR_TIMEOUT;
          end else begin
            to_q <= to_q + TO_BIT'(1);
          end
        end
        ST_DECODE: begin
          // Pattern/mode commit here so they are already stable during the load strobe.
          if (dec_err) begin
            code_q <= dec_code;
          end else if (!stop_bit) begin
            pattern_q <= pat_sh;
            for (int k = 0; k < CH_NUM; k++) begin
              if (ch == 4'(k)) mode_q[k] <= mode_bit;
            end
          end
        end
        ST_START: code_q <= idx_code(ACK_BASE, ch);
        default: ;
      endcase
    end
  end

  assign o_pattern      = pattern_q;
  assign o_ch_mode      = mode_q;
  assign o_ch_load      = load_v;
  assign o_ch_start     = start_v;
  assign o_ch_stop      = stop_v;
  assign o_tx_start     = tx_start;
  assign o_tx_data      = tx_data;
  assign o_overrun_tick = overrun;

endmodule

// File: tb/tb_serial_out_cmd_ctrl.sv
// Randomized and directed bench for serial_out_cmd_ctrl against a packet-level
// reference model (expected response code, strobes, pattern and mode).
module tb_serial_out_cmd_ctrl;

  localparam int CH_NUM = 2;
  localparam int TIMEOUT_CLK = 10420;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_tick = 1'b0;
  logic [1:0]  ch_busy = '0;
  logic [1:0]  ch_done = '0;
  logic        tx_done = 1'b0;
  logic [15:0] o_pattern;
  logic [1:0]  o_ch_mode, o_ch_load, o_ch_start, o_ch_stop;
  logic        o_tx_start, o_overrun_tick;
  logic [7:0]  o_tx_data;

  serial_out_cmd_ctrl #(
    .DATA_BIT(8), .PACK_NUM(3), .CH_NUM(CH_NUM), .TIMEOUT_CLK(TIMEOUT_CLK), .TO_BIT(14)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rx_data      (rx_data),
    .i_rx_done_tick (rx_tick),
    .i_ch_busy      (ch_busy),
    .i_ch_done_tick (ch_done),
    .o_pattern      (o_pattern),
    .o_ch_mode      (o_ch_mode),
    .o_ch_load      (o_ch_load),
    .o_ch_start     (o_ch_start),
    .o_ch_stop      (o_ch_stop),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .i_tx_done_tick (tx_done),
    .o_overrun_tick (o_overrun_tick)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int exp_ovr = 0;

  logic [7:0]  tx_q[$];
  int          tx_c[$];
  logic [1:0]  ld_q[$], st_q[$], sp_q[$];
  int          ld_c[$], st_c[$], sp_c[$];
  logic [15:0] ld_p[$];

  logic [15:0] m_pattern = '0;
  logic [1:0]  m_mode = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (|o_ch_load)  begin ld_q.push_back(o_ch_load);  ld_c.push_back(cyc); ld_p.push_back(o_pattern); end
    if (|o_ch_start) begin st_q.push_back(o_ch_start); st_c.push_back(cyc); end
    if (|o_ch_stop)  begin sp_q.push_back(o_ch_stop);  sp_c.push_back(cyc); end
    if (o_tx_start)  begin tx_q.push_back(o_tx_data);  tx_c.push_back(cyc); end
    if (o_overrun_tick) ovr_cnt++;
    if (|{o_ch_load, o_ch_start, o_ch_stop})
      check("strobe_excl", ($countones({o_ch_load, o_ch_start, o_ch_stop}) <= 1), 1);
  end

  initial begin
    #(100 * 90000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, output int t);
    rx_data = b;
    rx_tick = 1'b1;
    t = cyc;
    tick_n(1);
    rx_tick = 1'b0;
  endtask

  task automatic finish_tx();
    tick_n($urandom_range(1, 4));
    tx_done = 1'b1;
    tick_n(1);
    tx_done = 1'b0;
    tick_n(1);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp, input bit do_done, output int tcyc);
    int n = 0;
    tcyc = -1;
    while (tx_q.size() == 0 && n < 20000) begin tick_n(1); n++; end
    check({tag, "_seen"}, tx_q.size() > 0, 1);
    if (tx_q.size() > 0) begin
      check(tag, tx_q.pop_front(), exp);
      tcyc = tx_c.pop_front();
      check({tag, "_hold"}, o_tx_data, exp);
      if (do_done) finish_tx();
    end
  endtask

  task automatic clear_strobes();
    ld_q.delete(); ld_c.delete(); ld_p.delete();
    st_q.delete(); st_c.delete(); sp_q.delete(); sp_c.delete();
  endtask

  // Packet-level model: the response code and strobes follow from the
  // control byte fields and the busy vector alone.
  task automatic run_pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] c, input logic [1:0] busy, input logic [1:0] mid_done);
    int t, tc, ch;
    logic [7:0] code;
    bit err;
    clear_strobes();
    ch_busy = busy;
    tick_n($urandom_range(0, 4));
    send_byte(b0, t);
    if (mid_done != 0) begin ch_done = mid_done; tick_n(1); ch_done = '0; end
    tick_n($urandom_range(0, 4));
    send_byte(b1, t);
    tick_n($urandom_range(0, 4));
    send_byte(c, t);
    ch = (c >> 3) & 15;
    if (ch >= CH_NUM)              code = 8'hE2;
    else if (c[0] && c[1])         code = 8'hE3;
    else if (c[0] && busy[ch])     code = 8'hE4;
    else                           code = 8'hA0 + 8'(ch);
    err = (code[7:4] == 4'hE);
    expect_tx(tag, code, 1'b0, tc);
    check({tag, "_lat"}, tc - t, err ? 2 : 4);
    if (err) begin
      check({tag, "_nostrobe"}, ld_q.size() + sp_q.size() + st_q.size(), 0);
    end else begin
      if (c[1]) begin
        check({tag, "_stop_n"}, sp_q.size(), 1);
        check({tag, "_noload"}, ld_q.size(), 0);
        if (sp_q.size() > 0) begin
          check({tag, "_stop_vec"}, sp_q[0], 1 << ch);
          check({tag, "_stop_lat"}, sp_c[0] - t, 2);
        end
      end else begin
        m_pattern = {b0, b1};
        m_mode[ch] = c[2];
        check({tag, "_load_n"}, ld_q.size(), 1);
        check({tag, "_nostop"}, sp_q.size(), 0);
        if (ld_q.size() > 0) begin
          check({tag, "_load_vec"}, ld_q[0], 1 << ch);
          check({tag, "_load_lat"}, ld_c[0] - t, 2);
          check({tag, "_load_pat"}, ld_p[0], {b0, b1});
        end
      end
      check({tag, "_start_n"}, st_q.size(), c[0] ? 1 : 0);
      if (c[0] && st_q.size() > 0) begin
        check({tag, "_start_vec"}, st_q[0], 1 << ch);
        check({tag, "_start_lat"}, st_c[0] - t, 3);
      end
    end
    check({tag, "_pattern"}, o_pattern, m_pattern);
    check({tag, "_mode"}, o_ch_mode, m_mode);
    finish_tx();
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b1;
    #1;
    check(tag, {o_pattern, o_ch_mode, o_ch_load, o_ch_start, o_ch_stop,
                o_tx_start, o_tx_data, o_overrun_tick}, 0);
    m_pattern = '0;
    m_mode = '0;
    tick_n(2);
    rst_n = 1'b0;
    tick_n(2);
  endtask

  initial begin
    int t, tc;
    logic [7:0] c;
    tick_n(3);
    check("reset_state", {o_pattern, o_ch_mode, o_ch_load, o_ch_start, o_ch_stop,
                          o_tx_start, o_tx_data, o_overrun_tick}, 0);
    rst_n = 1'b0;
    tick_n(2);

    run_pkt("bad_ch", 8'h55, 8'h55, 8'h11, 2'b00, 2'b00);
    run_pkt("basic", 8'h55, 8'h55, 8'h01, 2'b00, 2'b00);

    clear_strobes();
    send_byte(8'h55, t);
    expect_tx("timeout", 8'hE1, 1'b0, tc);
    check("timeout_lat", tc - t, TIMEOUT_CLK + 1);
    check("timeout_nostrobe", ld_q.size() + st_q.size() + sp_q.size(), 0);
    check("timeout_pattern", o_pattern, m_pattern);
    finish_tx();
    run_pkt("after_to", 8'hAA, 8'h0F, 8'h0C, 2'b00, 2'b00);

    run_pkt("busy", 8'h00, 8'h00, 8'h01, 2'b01, 2'b00);
    run_pkt("stop", 8'h00, 8'h00, 8'h02, 2'b01, 2'b00);
    run_pkt("conflict", 8'h12, 8'h34, 8'h0B, 2'b00, 2'b00);

    ch_done = 2'b11;
    tick_n(1);
    ch_done = '0;
    expect_tx("notify0", 8'hD0, 1'b1, tc);
    expect_tx("notify1", 8'hD1, 1'b1, tc);

    run_pkt("held_pkt", 8'h12, 8'h34, 8'h01, 2'b00, 2'b10);
    expect_tx("held_notify", 8'hD1, 1'b1, tc);

    send_byte(8'h12, t);
    send_byte(8'h34, t);
    pulse_reset("rst_collect");
    run_pkt("post_rst1", 8'hC3, 8'h3C, 8'h0D, 2'b00, 2'b00);

    send_byte(8'h01, t);
    send_byte(8'h02, t);
    send_byte(8'h09, t);
    expect_tx("ackwait", 8'hA1, 1'b0, tc);
    begin
      int ovr0 = ovr_cnt;
      send_byte(8'hFF, t);
      tick_n(1);
      check("overrun", ovr_cnt - ovr0, 1);
      exp_ovr++;
    end
    pulse_reset("rst_ackwait");
    run_pkt("post_rst2", 8'h5A, 8'hA5, 8'h05, 2'b00, 2'b00);

    for (int i = 0; i < 40; i++) begin
      c = 8'($urandom);
      c[6:3] = 4'($urandom_range(0, 2));
      run_pkt("rand", 8'($urandom), 8'($urandom), c, 2'($urandom), 2'b00);
    end

    tick_n(5);
    check("no_stray_tx", tx_q.size(), 0);
    check("overrun_total", ovr_cnt, exp_ovr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
